// File: rtl/cdb_arbiter.sv
// -----------------------------------------------------------------------------
// cdb_arbiter
//
// Picks one finished functional-unit result per cycle and broadcasts it on the
// common data bus (CDB) through a single output register.
//
// Arbitration policy:
//   default              : round-robin from rr_ptr upward, with wrap-around
//   CDB_AGE_PRIO_EN      : oldest first, by (req_tag - rob_head) mod 2^TAG_W,
//                          lowest index on ties; no rr_ptr in this build
//
// Handshake (used on both sides): a transfer happens on a rising clock edge
// where valid and ready are both 1. req_ready is combinational and one-hot.
// The CDB register is "free" when it is empty or being drained this cycle.
//
// Ports:
//   clock, reset_n          clock; asynchronous active-low reset
//   req_valid [NUM_REQ]     requester i holds a completed result
//   req_tag   [NUM_REQ*TAG_W]  RoB tag of requester i (slice i)
//   req_value [NUM_REQ*DATA_W] result of requester i (slice i)
//   req_ready [NUM_REQ]     one-hot grant; result consumed at this edge
//   rob_head  [TAG_W]       RoB head tag (age priority only)
//   flush                   squash: no grant, broadcast dropped
//   cdb_ready               consumer accepts the broadcast
//   cdb_valid/tag/value/src registered broadcast and winner index
// -----------------------------------------------------------------------------
module cdb_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TAG_W   = 7,
  parameter int DATA_W  = 32,
  localparam int SRC_W  = $clog2(NUM_REQ)
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*TAG_W-1:0]  req_tag,
  input  logic [NUM_REQ*DATA_W-1:0] req_value,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [TAG_W-1:0]          rob_head,
  input  logic                      flush,
  input  logic                      cdb_ready,
  output logic                      cdb_valid,
  output logic [TAG_W-1:0]          cdb_tag,
  output logic [DATA_W-1:0]         cdb_value,
  output logic [SRC_W-1:0]          cdb_src
);

  logic              free;
  logic              grant_en;
  logic              win_any;
  logic [SRC_W-1:0]  win;
  logic [TAG_W-1:0]  win_tag;
  logic [DATA_W-1:0] win_value;
  logic [15:0]       stall_cnt;

  assign free = !cdb_valid || cdb_ready;
  // reset_n gates the grant so req_ready is zero throughout reset
  assign grant_en = reset_n && free && !flush && win_any;

`ifdef CDB_AGE_PRIO_EN
  // Age priority: distance from the RoB head; strict '<' keeps lowest index on ties
  logic [TAG_W-1:0] best_age;
  logic [TAG_W-1:0] age;

  always_comb begin
    best_age = '1;
    age      = '0;
    win      = '0;
    win_any  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      age = req_tag[i*TAG_W +: TAG_W] - rob_head;
      if (req_valid[i] && (!win_any || age < best_age)) begin
        best_age = age;
        win      = SRC_W'(i);
        win_any  = 1'b1;
      end
    end
  end
`else
  localparam logic [SRC_W:0] NUM_REQ_W = (SRC_W+1)'(NUM_REQ);

  logic [SRC_W-1:0] rr_ptr;
  logic [SRC_W-1:0] rr_next;
  logic [SRC_W:0]   idx;
  logic [SRC_W:0]   nxt;
  logic             unused_rob_head;

  assign unused_rob_head = ^rob_head;

  // Scan offsets from high to low so the smallest offset from rr_ptr wins
  always_comb begin
    idx     = '0;
    win     = '0;
    win_any = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = {1'b0, rr_ptr} + (SRC_W+1)'(k);
      if (idx >= NUM_REQ_W) idx = idx - NUM_REQ_W;
      if (req_valid[idx[SRC_W-1:0]]) begin
        win     = idx[SRC_W-1:0];
        win_any = 1'b1;
      end
    end
  end

  always_comb begin
    nxt = {1'b0, win} + (SRC_W+1)'(1);
    if (nxt == NUM_REQ_W) nxt = '0;
    rr_next = nxt[SRC_W-1:0];
  end

  // Pointer moves only on a real grant; flush and idle cycles leave it alone
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr <= '0;
    end else if (grant_en) begin
      rr_ptr <= rr_next;
    end
  end
`endif

  // One-hot grant and winner data mux
  always_comb begin
    req_ready = '0;
    win_tag   = '0;
    win_value = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = grant_en && (win == SRC_W'(i));
      if (win == SRC_W'(i)) begin
        win_tag   = req_tag[i*TAG_W +: TAG_W];
        win_value = req_value[i*DATA_W +: DATA_W];
      end
    end
  end

  // Output register and debug stall counter
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cdb_valid <= 1'b0;
      cdb_tag   <= '0;
      cdb_value <= '0;
      cdb_src   <= '0;
      stall_cnt <= '0;
    end else begin
      if (flush) begin
        cdb_valid <= 1'b0;
      end else if (free) begin
        if (grant_en) begin
          cdb_valid <= 1'b1;
          cdb_tag   <= win_tag;
          cdb_value <= win_value;
          cdb_src   <= win;
        end else begin
          cdb_valid <= 1'b0;
        end
      end
      if (cdb_valid && !cdb_ready && stall_cnt != 16'hFFFF) begin
        stall_cnt <= stall_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cdb_arbiter: directed test of cdb_arbiter (NUM_REQ=4, TAG_W=7, DATA_W=32).
// Inputs change just after the falling edge; outputs are sampled 1 time unit
// later, well away from the rising edge. Expected values are hand-computed.
// -----------------------------------------------------------------------------
module tb_cdb_arbiter;

  logic         clock;
  logic         reset_n;
  logic [3:0]   req_valid;
  logic [27:0]  req_tag;
  logic [127:0] req_value;
  logic [3:0]   req_ready;
  logic [6:0]   rob_head;
  logic         flush;
  logic         cdb_ready;
  logic         cdb_valid;
  logic [6:0]   cdb_tag;
  logic [31:0]  cdb_value;
  logic [1:0]   cdb_src;

  int n_pass  = 0;
  int n_total = 0;
  logic [6:0] tg [4];

  cdb_arbiter dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_tag   (req_tag),
    .req_value (req_value),
    .req_ready (req_ready),
    .rob_head  (rob_head),
    .flush     (flush),
    .cdb_ready (cdb_ready),
    .cdb_valid (cdb_valid),
    .cdb_tag   (cdb_tag),
    .cdb_value (cdb_value),
    .cdb_src   (cdb_src)
  );

  // clock / reset block
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic logic [31:0] val_of(input int i);
    return 32'hA000_0000 | 32'(i);
  endfunction

  // driver task
  task automatic drive_tags();
    req_tag   = {tg[3], tg[2], tg[1], tg[0]};
    req_value = {val_of(3), val_of(2), val_of(1), val_of(0)};
  endtask

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
  endtask

  // Grant vector, broadcast valid, and (if valid) broadcast from requester es
  task automatic step(input string name, input logic [3:0] er, input logic ev, input int es);
    chk({name, ".ready"}, 32'(req_ready), 32'(er));
    chk({name, ".valid"}, 32'(cdb_valid), 32'(ev));
    if (ev) begin
      chk({name, ".tag"},   32'(cdb_tag),   32'(tg[es]));
      chk({name, ".value"}, cdb_value,      val_of(es));
      chk({name, ".src"},   32'(cdb_src),   32'(es));
    end
  endtask

  task automatic chk_zero_out(input string name);
    chk({name, ".valid"}, 32'(cdb_valid), 32'd0);
    chk({name, ".tag"},   32'(cdb_tag),   32'd0);
    chk({name, ".value"}, cdb_value,      32'd0);
    chk({name, ".src"},   32'(cdb_src),   32'd0);
    chk({name, ".ready"}, 32'(req_ready), 32'd0);
  endtask

  initial begin
    reset_n   = 1'b0;
    flush     = 1'b0;
    cdb_ready = 1'b1;
    rob_head  = 7'h00;
    req_valid = 4'b1111;
    tg[0] = 7'h10; tg[1] = 7'h05; tg[2] = 7'h12; tg[3] = 7'h13;
    drive_tags();

    // reset state, even with all requesters valid
    #2;
    chk_zero_out("reset");
    chk("reset.stall", 32'(dut.stall_cnt), 32'd0);

`ifdef CDB_AGE_PRIO_EN
    // oldest-first: ages from head 0x7E are {3,1,5,0}
    @(negedge clock);
    rob_head = 7'h7E;
    tg[0] = 7'h01; tg[1] = 7'h7F; tg[2] = 7'h03; tg[3] = 7'h7E;
    drive_tags();
    reset_n = 1'b1;
    #1 step("age0", 4'b1000, 1'b0, 0);
    @(negedge clock); req_valid = 4'b0111;
    #1 step("age1", 4'b0010, 1'b1, 3);
    @(negedge clock); req_valid = 4'b0101;
    #1 step("age2", 4'b0001, 1'b1, 1);
    @(negedge clock); req_valid = 4'b0100;
    #1 step("age3", 4'b0100, 1'b1, 0);
`else
    chk("reset.rr_ptr", 32'(dut.rr_ptr), 32'd0);

    // alternating grants 0,2,0,2 with one-cycle broadcast latency
    @(negedge clock); reset_n = 1'b1; req_valid = 4'b0101;
    #1 step("alt0", 4'b0001, 1'b0, 0);
    @(negedge clock); #1 step("alt1", 4'b0100, 1'b1, 0);
    @(negedge clock); #1 step("alt2", 4'b0001, 1'b1, 2);
    @(negedge clock); #1 step("alt3", 4'b0100, 1'b1, 0);
    @(negedge clock); req_valid = 4'b0000;
    #1 step("alt4", 4'b0000, 1'b1, 2);
    @(negedge clock);
    #1 step("idle", 4'b0000, 1'b0, 0);
    chk("idle.rr_ptr", 32'(dut.rr_ptr), 32'd3);

    // stall: tag 0x05 held three cycles with cdb_ready low
    req_valid = 4'b0010; cdb_ready = 1'b0;
    #1 step("stall_g", 4'b0010, 1'b0, 0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      #1 step($sformatf("stall%0d", c), 4'b0000, 1'b1, 1);
      chk($sformatf("stall%0d.cnt", c), 32'(dut.stall_cnt), 32'(c));
    end
    @(negedge clock);
    #1 step("stall3", 4'b0000, 1'b1, 1);
    chk("stall3.cnt", 32'(dut.stall_cnt), 32'd3);
    chk("stall3.rr_ptr", 32'(dut.rr_ptr), 32'd2);
    cdb_ready = 1'b1; req_valid = 4'b0000;
    @(negedge clock);
    #1 step("drain", 4'b0000, 1'b0, 0);
    chk("drain.cnt", 32'(dut.stall_cnt), 32'd3);

    // reset again to bring rr_ptr to 0, then full contention 0,1,2,3,0
    reset_n = 1'b0;
    #1 chk("rr_rst.rr_ptr", 32'(dut.rr_ptr), 32'd0);
    @(negedge clock); reset_n = 1'b1; req_valid = 4'b1111;
    #1 step("rr0", 4'b0001, 1'b0, 0);
    @(negedge clock); #1 step("rr1", 4'b0010, 1'b1, 0);
    @(negedge clock); #1 step("rr2", 4'b0100, 1'b1, 1);
    @(negedge clock); #1 step("rr3", 4'b1000, 1'b1, 2);
    @(negedge clock); #1 step("rr4", 4'b0001, 1'b1, 3);

    // flush with a broadcast pending and everyone requesting
    @(negedge clock); flush = 1'b1;
    #1 step("flush", 4'b0000, 1'b1, 0);
    chk("flush.rr_ptr", 32'(dut.rr_ptr), 32'd1);
    @(negedge clock); flush = 1'b0;
    #1 step("post_flush", 4'b0010, 1'b0, 0);
    chk("post_flush.rr_ptr", 32'(dut.rr_ptr), 32'd1);

    // reset between grant and broadcast
    @(negedge clock);
    #1 step("pre_rst", 4'b0100, 1'b1, 1);
    #1 reset_n = 1'b0;
    #1 chk_zero_out("mid_rst");
    @(negedge clock); req_valid = 4'b0000; reset_n = 1'b1;
    #1 chk_zero_out("rel_rst");
    @(negedge clock);
    #1 chk_zero_out("no_stale");
    req_valid = 4'b1000;
    #1 step("resume_g", 4'b1000, 1'b0, 0);
    @(negedge clock); req_valid = 4'b0000;
    #1 step("resume", 4'b0000, 1'b1, 3);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
